// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: pipelined converter from a two's-complement sample to a small
// floating-point triple (sign, exponent, significand) with selectable rounding
// and inexact/saturation flags. Streams at one word per cycle over valid/ready.
module fpcvt_pipe #(
  parameter  int EW = 3,
  parameter  int MW = 4,
  localparam int DW = 1 + MW + (1 << EW) - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_d,
  input  logic [1:0]    in_rmode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [MW-1:0] out_f,
  output logic          out_inexact,
  output logic          out_sat
);

  localparam int MAGW = DW - 1;
  localparam logic [EW-1:0] EMAX = '1;

  typedef enum logic [1:0] {
    RM_HALF_UP   = 2'b00,
    RM_TRUNC     = 2'b01,
    RM_HALF_EVEN = 2'b10,
    RM_RSVD      = 2'b11
  } rmode_e;

  logic advance;

  // Input capture register: raw sample plus the rounding mode that travels with it.
  logic          v0_q;
  logic [DW-1:0] d0_q;
  rmode_e        rm0_q;

  // Sign/magnitude stage.
  logic            v1_q, s1_q, forced1_q;
  logic [MAGW-1:0] m1_q;
  rmode_e          rm1_q;
  logic            s1_d, forced1_d;
  logic [MAGW-1:0] m1_d;

  // Normalise stage.
  logic          v2_q, s2_q, forced2_q, r2_q, st2_q;
  logic [EW-1:0] e2_q;
  logic [MW-1:0] f2_q;
  rmode_e        rm2_q;
  logic [EW-1:0] e2_d;
  logic [MW-1:0] f2_d;
  logic          r2_d, st2_d;
  int            pos, shiftN;

  // Round stage, whose registers are the outputs.
  logic          vo_q, so_q, inex_q, sat_q;
  logic [EW-1:0] eo_q;
  logic [MW-1:0] fo_q;
  logic [EW-1:0] eo_d;
  logic [MW-1:0] fo_d;
  logic          inex_d, sat_d, roundUp;
  logic [MW:0]   fSum;

  // Every stage moves together whenever the output slot is empty or being drained.
  assign advance  = !vo_q || out_ready;
  assign in_ready = advance;

  // Capture the accepted word; bubbles leave the stored data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q  <= 1'b0;
      d0_q  <= '0;
      rm0_q <= RM_HALF_UP;
    end else if (advance) begin
      v0_q <= in_valid;
      if (in_valid) begin
        d0_q  <= in_d;
        rm0_q <= rmode_e'(in_rmode);
      end
    end
  end

  // Split into sign and magnitude; the most negative sample has no positive twin
  // so it is pinned to the largest magnitude and flagged.
  always_comb begin
    s1_d      = d0_q[DW-1];
    forced1_d = s1_d && (d0_q[MAGW-1:0] == '0);
    if (forced1_d) begin
      m1_d = '1;
    end else if (s1_d) begin
      m1_d = (~d0_q[MAGW-1:0]) + MAGW'(1);
    end else begin
      m1_d = d0_q[MAGW-1:0];
    end
  end

  // Sign/magnitude pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_q      <= 1'b0;
      forced1_q <= 1'b0;
      m1_q      <= '0;
      rm1_q     <= RM_HALF_UP;
    end else if (advance) begin
      v1_q <= v0_q;
      if (v0_q) begin
        s1_q      <= s1_d;
        forced1_q <= forced1_d;
        m1_q      <= m1_d;
        rm1_q     <= rm0_q;
      end
    end
  end

  // Find the leading one and slice out the significand, round bit and sticky bit;
  // small magnitudes fit the significand directly with a zero exponent.
  always_comb begin
    pos    = 0;
    shiftN = 0;
    e2_d   = '0;
    f2_d   = m1_q[MW-1:0];
    r2_d   = 1'b0;
    st2_d  = 1'b0;
    for (int i = 0; i < MAGW; i++) begin
      if (m1_q[i]) pos = i;
    end
    if (pos >= MW) begin
      shiftN = pos - MW + 1;
      e2_d   = EW'(shiftN);
      f2_d   = MW'(m1_q >> shiftN);
      for (int i = 0; i < MAGW; i++) begin
        if (i == shiftN - 1) r2_d = m1_q[i];
        if (i < shiftN - 1) st2_d = st2_d | m1_q[i];
      end
    end
  end

  // Normalise pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q      <= 1'b0;
      s2_q      <= 1'b0;
      forced2_q <= 1'b0;
      e2_q      <= '0;
      f2_q      <= '0;
      r2_q      <= 1'b0;
      st2_q     <= 1'b0;
      rm2_q     <= RM_HALF_UP;
    end else if (advance) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q      <= s1_q;
        forced2_q <= forced1_q;
        e2_q      <= e2_d;
        f2_q      <= f2_d;
        r2_q      <= r2_d;
        st2_q     <= st2_d;
        rm2_q     <= rm1_q;
      end
    end
  end

  // Apply the word's rounding mode; a carry out of the significand renormalises,
  // and a carry at the top exponent clamps to the largest representable value.
  always_comb begin
    case (rm2_q)
      RM_TRUNC:     roundUp = 1'b0;
      RM_HALF_EVEN: roundUp = r2_q && (st2_q || f2_q[0]);
      default:      roundUp = r2_q;
    endcase
    fSum   = {1'b0, f2_q} + {{MW{1'b0}}, roundUp};
    eo_d   = e2_q;
    fo_d   = fSum[MW-1:0];
    sat_d  = forced2_q;
    inex_d = r2_q | st2_q | forced2_q;
    if (fSum[MW]) begin
      if (e2_q == EMAX) begin
        fo_d  = '1;
        eo_d  = EMAX;
        sat_d = 1'b1;
      end else begin
        fo_d = {1'b1, {(MW-1){1'b0}}};
        eo_d = e2_q + EW'(1);
      end
    end
  end

  // Output register; holds while the downstream is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vo_q   <= 1'b0;
      so_q   <= 1'b0;
      eo_q   <= '0;
      fo_q   <= '0;
      inex_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (advance) begin
      vo_q <= v2_q;
      if (v2_q) begin
        so_q   <= s2_q;
        eo_q   <= eo_d;
        fo_q   <= fo_d;
        inex_q <= inex_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign out_valid   = vo_q;
  assign out_s       = so_q;
  assign out_e       = eo_q;
  assign out_f       = fo_q;
  assign out_inexact = inex_q;
  assign out_sat     = sat_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Testbench for fpcvt_pipe: hand-computed vectors at default parameters, a
// stalled back-to-back stream, and a reset with words in flight.
module tb_fpcvt_pipe;

  localparam int EW = 3;
  localparam int MW = 4;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_d;
  logic [1:0]    in_rmode;
  logic          out_valid;
  logic          out_ready;
  logic          out_s;
  logic [EW-1:0] out_e;
  logic [MW-1:0] out_f;
  logic          out_inexact;
  logic          out_sat;

  typedef struct {
    logic [DW-1:0] din;
    logic [1:0]    rmode;
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] f;
    logic          inex;
    logic          sat;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int compared;
  int mismatched;

  fpcvt_pipe #(.EW(EW), .MW(MW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_d        (in_d),
    .in_rmode    (in_rmode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .out_e       (out_e),
    .out_f       (out_f),
    .out_inexact (out_inexact),
    .out_sat     (out_sat)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] expPack(input vec_t v);
    return 16'({v.s, v.e, v.f, v.inex, v.sat});
  endfunction

  function automatic logic [15:0] actPack();
    return 16'({out_s, out_e, out_f, out_inexact, out_sat});
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push one word through an otherwise idle pipeline and report the latency
  // in clock edges from acceptance to out_valid.
  task automatic applyStimulus(input logic [DW-1:0] din, input logic [1:0] rm, output int lat);
    in_valid = 1'b1;
    in_d     = din;
    in_rmode = rm;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int inIdx;
    int outIdx;
    int extra;

    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{12'h000, 2'b00, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{12'h07D, 2'b00, 1'b0, 3'd4, 4'h8, 1'b1, 1'b0};
    vecs[2]  = '{12'h07D, 2'b01, 1'b0, 3'd3, 4'hF, 1'b1, 1'b0};
    vecs[3]  = '{12'h0E8, 2'b00, 1'b0, 3'd4, 4'hF, 1'b1, 1'b0};
    vecs[4]  = '{12'h0E8, 2'b10, 1'b0, 3'd4, 4'hE, 1'b1, 1'b0};
    vecs[5]  = '{12'h800, 2'b00, 1'b1, 3'd7, 4'hF, 1'b1, 1'b1};
    vecs[6]  = '{12'h7FF, 2'b00, 1'b0, 3'd7, 4'hF, 1'b1, 1'b1};
    vecs[7]  = '{12'hFFF, 2'b00, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0};
    vecs[8]  = '{12'h00F, 2'b00, 1'b0, 3'd0, 4'hF, 1'b0, 1'b0};
    vecs[9]  = '{12'h010, 2'b00, 1'b0, 3'd1, 4'h8, 1'b0, 1'b0};
    vecs[10] = '{12'h019, 2'b10, 1'b0, 3'd1, 4'hC, 1'b1, 1'b0};
    vecs[11] = '{12'h019, 2'b11, 1'b0, 3'd1, 4'hD, 1'b1, 1'b0};
    vecs[12] = '{12'h01F, 2'b10, 1'b0, 3'd2, 4'h8, 1'b1, 1'b0};
    vecs[13] = '{12'h7FF, 2'b01, 1'b0, 3'd7, 4'hF, 1'b1, 1'b0};
    vecs[14] = '{12'h800, 2'b01, 1'b1, 3'd7, 4'hF, 1'b1, 1'b1};
    vecs[15] = '{12'hF83, 2'b00, 1'b1, 3'd4, 4'h8, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_d      = '0;
    in_rmode  = 2'b00;
    out_ready = 1'b1;

    // Reset state.
    #3;
    checkOutput("resetValid", 16'(out_valid), 16'd0);
    checkOutput("resetOutputs", actPack(), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("inReadyAfterReset", 16'(in_ready), 16'd1);
    @(negedge clk);

    // Single words, each checked for value and latency.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].din, vecs[i].rmode, lat);
      checkOutput($sformatf("latency%0d", i), 16'(lat), 16'd3);
      checkOutput($sformatf("result%0d", i), actPack(), expPack(vecs[i]));
    end
    @(posedge clk);
    @(negedge clk);

    // Back-to-back stream of six words with a four-cycle downstream stall.
    $display("[TB] stream with stall");
    inIdx  = 0;
    outIdx = 0;
    for (int c = 0; c < 60 && outIdx < 6; c++) begin
      out_ready = !(c >= 5 && c <= 8);
      in_valid  = (inIdx < 6);
      if (inIdx < 6) begin
        in_d     = vecs[1 + inIdx].din;
        in_rmode = vecs[1 + inIdx].rmode;
      end
      #1;
      if (c == 5) checkOutput("inReadyFall", 16'({out_valid, in_ready}), 16'b10);
      if (c == 9) checkOutput("inReadyRise", 16'(in_ready), 16'd1);
      if (out_valid) begin
        checkOutput(out_ready ? $sformatf("streamPop%0d", outIdx) : $sformatf("stallHold%0d", outIdx),
                    actPack(), expPack(vecs[1 + outIdx]));
        if (out_ready) outIdx++;
      end else if (!out_ready) begin
        checkOutput("stallValid", 16'(out_valid), 16'd1);
      end
      if (in_valid && in_ready) inIdx++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("streamCount", 16'(outIdx), 16'd6);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) extra++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("noDuplicates", 16'(extra), 16'd0);

    // Reset with three words in flight.
    $display("[TB] reset mid-stream");
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_d     = vecs[1 + k].din;
      in_rmode = vecs[1 + k].rmode;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("preResetValid", 16'(out_valid), 16'd1);
    checkOutput("preResetData", actPack(), expPack(vecs[1]));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midResetValid", 16'(out_valid), 16'd0);
    checkOutput("midResetOutputs", actPack(), 16'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) extra++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("flushedWords", 16'(extra), 16'd0);
    applyStimulus(vecs[9].din, vecs[9].rmode, lat);
    checkOutput("postResetLatency", 16'(lat), 16'd3);
    checkOutput("postResetResult", actPack(), expPack(vecs[9]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
